job_sequencer: RTL and testbench

- Sequences one mining job through the SHA datapath: loads an 8-word midstate, then a 16-word header, runs the solve, and returns each golden nonce to the host over a claim/response handshake.
- Sits between the host word stream and the midstate/header shift registers plus the SHA block. It replaces free-running timer-based shift counting with valid/ready word acceptance and explicit nonce-exhaustion handling.

---
 rtl/job_sequencer.sv | 166 ++++++++++++++++
 tb/tb_job_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/job_sequencer.sv
// Job sequencer: streams midstate then header words into the SHA shift registers, runs the solve, and hands each golden nonce to the host.
// Optional build macro JOB_SEQ_CLAIM_TIMEOUT_EN adds a claim timeout and the sticky claim_lost output.
module job_sequencer #(
  parameter int unsigned MID_WORDS  = 8,
  parameter int unsigned HEAD_WORDS = 16
`ifdef JOB_SEQ_CLAIM_TIMEOUT_EN
  , parameter int unsigned CLAIM_TIMEOUT = 1024
`endif
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start_found,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        sr_clear,
  output logic        mid_shift,
  output logic        head_shift,
  output logic        core_load,
  output logic        core_solve,
  input  logic        core_flag,
  input  logic [31:0] core_nonce,
  input  logic        core_done,
  output logic        sol_claim,
  input  logic        sol_response,
  output logic [31:0] out_data,
  output logic        need_work,
`ifdef JOB_SEQ_CLAIM_TIMEOUT_EN
  output logic        claim_lost,
`endif
  output logic        busy
);

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] MID_LAST  = CNT_W'(MID_WORDS - 1);
  localparam logic [CNT_W-1:0] HEAD_LAST = CNT_W'(HEAD_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MID, S_HEAD, S_SOLVE, S_CLAIM, S_EXHAUST
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] word_cnt, word_cnt_nxt;
  logic             done_pend, done_pend_nxt;
  logic [31:0]      out_data_nxt;
  logic             accept;
  logic             timeout_hit;
  logic             claim_release;

  // The payload word stream never feeds the sequencer's own state.
  logic unused_in_data;
  assign unused_in_data = ^in_data;

  // Handshake and shift strobes depend on live inputs, so they stay combinational.
  assign sr_clear   = (state == S_IDLE) || start_found;
  assign in_ready   = ((state == S_MID) || (state == S_HEAD)) && !start_found;
  assign accept     = in_valid && in_ready;
  assign mid_shift  = accept && (state == S_MID);
  assign head_shift = accept && (state == S_HEAD);

`ifdef JOB_SEQ_CLAIM_TIMEOUT_EN
  logic [15:0] claim_cnt;

  assign timeout_hit = (state == S_CLAIM) && (claim_cnt == 16'(CLAIM_TIMEOUT - 1));

  // Claim age counter restarts on every entry into CLAIM.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      claim_cnt  <= '0;
      claim_lost <= 1'b0;
    end else begin
      if (state != S_CLAIM) claim_cnt <= '0;
      else                  claim_cnt <= claim_cnt + 16'd1;
      if (start_found)                       claim_lost <= 1'b0;
      else if (timeout_hit && !sol_response) claim_lost <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign claim_release = sol_response || timeout_hit;

  // Next-state logic; start_found overrides everything.
  always_comb begin
    state_nxt     = state;
    word_cnt_nxt  = word_cnt;
    done_pend_nxt = done_pend;
    out_data_nxt  = out_data;
    if (start_found) begin
      state_nxt     = S_MID;
      word_cnt_nxt  = '0;
      done_pend_nxt = 1'b0;
    end else begin
      case (state)
        S_MID: begin
          if (accept) begin
            if (word_cnt == MID_LAST) begin
              word_cnt_nxt = '0;
              state_nxt    = S_HEAD;
            end else begin
              word_cnt_nxt = word_cnt + CNT_W'(1);
            end
          end
        end
        S_HEAD: begin
          if (accept) begin
            if (word_cnt == HEAD_LAST) begin
              word_cnt_nxt = '0;
              state_nxt    = S_SOLVE;
            end else begin
              word_cnt_nxt = word_cnt + CNT_W'(1);
            end
          end
        end
        S_SOLVE: begin
          if (core_flag) begin
            out_data_nxt = core_nonce;
            state_nxt    = S_CLAIM;
            if (core_done) done_pend_nxt = 1'b1;
          end else if (core_done) begin
            state_nxt = S_EXHAUST;
          end
        end
        S_CLAIM: begin
          if (core_done) done_pend_nxt = 1'b1;
          // An exhaustion reported alongside the release is not lost.
          if (claim_release) state_nxt = (done_pend || core_done) ? S_EXHAUST : S_SOLVE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      word_cnt  <= '0;
      done_pend <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      word_cnt  <= word_cnt_nxt;
      done_pend <= done_pend_nxt;
      out_data  <= out_data_nxt;
    end
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      core_load  <= 1'b0;
      core_solve <= 1'b0;
      sol_claim  <= 1'b0;
      need_work  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      core_load  <= (state_nxt == S_MID) || (state_nxt == S_HEAD);
      core_solve <= (state_nxt == S_SOLVE);
      sol_claim  <= (state_nxt == S_CLAIM);
      need_work  <= (state_nxt == S_EXHAUST);
      busy       <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_job_sequencer.sv
// Randomized self-checking bench for job_sequencer against a job-phase reference model.
module tb_job_sequencer;

  localparam int TB_TO = 16;
  localparam int P_IDLE = 0, P_LOAD = 1, P_SOLVE = 2, P_CLAIM = 3, P_EXH = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start_found, in_valid, core_flag, core_done, sol_response;
  logic [31:0] in_data, core_nonce;
  logic        in_ready, sr_clear, mid_shift, head_shift, core_load, core_solve;
  logic        sol_claim, need_work, busy;
  logic [31:0] out_data;
`ifdef JOB_SEQ_CLAIM_TIMEOUT_EN
  logic        claim_lost;
`endif

  job_sequencer #(
    .MID_WORDS(8), .HEAD_WORDS(16)
`ifdef JOB_SEQ_CLAIM_TIMEOUT_EN
    , .CLAIM_TIMEOUT(TB_TO)
`endif
  ) dut (
    .clk(clk), .n_rst(n_rst), .start_found(start_found),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sr_clear(sr_clear), .mid_shift(mid_shift), .head_shift(head_shift),
    .core_load(core_load), .core_solve(core_solve),
    .core_flag(core_flag), .core_nonce(core_nonce), .core_done(core_done),
    .sol_claim(sol_claim), .sol_response(sol_response), .out_data(out_data),
    .need_work(need_work),
`ifdef JOB_SEQ_CLAIM_TIMEOUT_EN
    .claim_lost(claim_lost),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: job phase, words taken so far, pending exhaustion, latched nonce.
  int          m_phase = P_IDLE;
  int          m_words = 0;
  bit          m_pend  = 1'b0;
  logic [31:0] m_nonce = '0;
  int          m_age   = 0;
  bit          m_lost  = 1'b0;
  int          n_mid, n_head;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit rdy;
    rdy = (m_phase == P_LOAD) && !start_found;
    check("sr_clear",   32'(sr_clear),   32'((m_phase == P_IDLE) || start_found));
    check("in_ready",   32'(in_ready),   32'(rdy));
    check("mid_shift",  32'(mid_shift),  32'(rdy && in_valid && (m_words < 8)));
    check("head_shift", 32'(head_shift), 32'(rdy && in_valid && (m_words >= 8)));
    check("core_load",  32'(core_load),  32'(m_phase == P_LOAD));
    check("core_solve", 32'(core_solve), 32'(m_phase == P_SOLVE));
    check("sol_claim",  32'(sol_claim),  32'(m_phase == P_CLAIM));
    check("need_work",  32'(need_work),  32'(m_phase == P_EXH));
    check("busy",       32'(busy),       32'(m_phase != P_IDLE));
    check("out_data",   out_data,        m_nonce);
`ifdef JOB_SEQ_CLAIM_TIMEOUT_EN
    check("claim_lost", 32'(claim_lost), 32'(m_lost));
`endif
  endtask

  task automatic model_update();
    bit release_now, timed_out;
    if (start_found) begin
      m_phase = P_LOAD; m_words = 0; m_pend = 1'b0; m_lost = 1'b0;
      return;
    end
    case (m_phase)
      P_LOAD: if (in_valid) begin
        m_words++;
        if (m_words == 24) m_phase = P_SOLVE;
      end
      P_SOLVE: if (core_flag) begin
        m_nonce = core_nonce; m_pend = core_done; m_phase = P_CLAIM; m_age = 0;
      end else if (core_done) begin
        m_phase = P_EXH;
      end
      P_CLAIM: begin
        timed_out = 1'b0;
`ifdef JOB_SEQ_CLAIM_TIMEOUT_EN
        timed_out = (m_age == TB_TO - 1);
`endif
        if (core_done) m_pend = 1'b1;
        release_now = sol_response || timed_out;
        if (timed_out && !sol_response) m_lost = 1'b1;
        if (release_now) m_phase = m_pend ? P_EXH : P_SOLVE;
        m_age++;
      end
      default: ;
    endcase
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model, pass the rising edge.
  task automatic step(input bit st, input bit v, input logic [31:0] d, input bit fl,
                      input logic [31:0] nn, input bit dn, input bit rs);
    start_found = st; in_valid = v; in_data = d;
    core_flag = fl; core_nonce = nn; core_done = dn; sol_response = rs;
    @(negedge clk);
    check_outputs();
    if (mid_shift)  n_mid++;
    if (head_shift) n_head++;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  initial begin
    n_rst = 1'b0;
    start_found = 0; in_valid = 0; in_data = '0;
    core_flag = 0; core_nonce = '0; core_done = 0; sol_response = 0;
    #12;
    check_outputs();
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    idle(2);

    // Back-to-back job, then solve latency.
    step(1, 0, 32'h0, 0, 32'h0, 0, 0);
    n_mid = 0; n_head = 0;
    for (int i = 1; i <= 24; i++) step(0, 1, 32'(i), 0, 32'h0, 0, 0);
    check("b2b_mid_count",  32'(n_mid), 32'd8);
    check("b2b_head_count", 32'(n_head), 32'd16);
    @(negedge clk);
    check("solve_after_word24", 32'(core_solve), 32'd1);
    @(posedge clk); #1;

    // Golden nonce claimed, answered after 5 cycles.
    step(0, 0, 32'h0, 1, 32'hDEADBEEF, 0, 0);
    idle(4);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);
    idle(2);

    // Simultaneous flag and exhaustion.
    step(0, 0, 32'h0, 1, 32'h12345678, 1, 0);
    idle(2);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);
    idle(3);
    check("exhaust_need_work", 32'(need_work), 32'd1);

    // Stalled job: in_valid every other cycle.
    step(1, 0, 32'h0, 0, 32'h0, 0, 0);
    n_mid = 0; n_head = 0;
    for (int i = 0; i < 48; i++) step(0, (i % 2) == 0, 32'(i / 2 + 1), 0, 32'h0, 0, 0);
    idle(2);
    check("stall_mid_count",  32'(n_mid), 32'd8);
    check("stall_head_count", 32'(n_head), 32'd16);

    // Abort after 5 header words, restart cleanly.
    step(1, 0, 32'h0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 13; i++) step(0, 1, 32'(i), 0, 32'h0, 0, 0);
    step(1, 1, 32'hFFFF_FFFF, 0, 32'h0, 0, 0);
    n_mid = 0; n_head = 0;
    for (int i = 0; i < 8; i++) step(0, 1, 32'(100 + i), 0, 32'h0, 0, 0);
    check("restart_mid_count", 32'(n_mid), 32'd8);
    for (int i = 0; i < 16; i++) step(0, 1, 32'(200 + i), 0, 32'h0, 0, 0);

    // Unanswered claim.
    step(0, 0, 32'h0, 1, 32'hCAFE_F00D, 0, 0);
    idle(20);

    // Asynchronous reset in the middle of a job.
    step(1, 0, 32'h0, 0, 32'h0, 0, 0);
    step(0, 1, 32'h1, 0, 32'h0, 0, 0);
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_busy",     32'(busy), 32'd0);
    check("async_rst_out_data", out_data, 32'd0);
    check("async_rst_sr_clear", 32'(sr_clear), 32'd1);
    m_phase = P_IDLE; m_words = 0; m_pend = 1'b0; m_nonce = '0; m_lost = 1'b0;
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           $urandom,
           $urandom_range(0, 19) == 0,
           $urandom,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
